seq_div_4bits: RTL and testbench



---
 rtl/seq_div_4bits.sv | 172 +++++++++++++++++
 tb/tb_seq_div_4bits.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_4bits.sv
// rtl/seq_div_4bits.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional signed mode (port M, two's complement operands) is compiled in with DIV_SIGNED_EN.
module seq_div_4bits #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef DIV_SIGNED_EN
  input  logic             M,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;
  logic             r_v;

  logic             w_m;
  logic             w_accept;
  logic             w_last;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic             w_v_fin;

`ifdef DIV_SIGNED_EN
  assign w_m = M;
`else
  assign w_m = 1'b0;
`endif

  assign w_accept = start && (r_state != S_CALC);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Operands are reduced to magnitudes up front; the most-negative value maps to itself,
  // which is its correct unsigned magnitude.
  assign w_neg_a = w_m & A[WIDTH-1];
  assign w_neg_b = w_m & B[WIDTH-1];
  assign w_a_mag = w_neg_a ? -A : A;
  assign w_b_mag = w_neg_b ? -B : B;

  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_div};
  assign w_rem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

  // Sign fix-up happens on the same edge that enters DONE, so signed latency matches unsigned.
  assign w_q_fin = (r_neg_a ^ r_neg_b) ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fin = r_neg_a ? -w_rem_nxt : w_rem_nxt;
  assign w_v_fin = r_neg_a & r_neg_b & w_quo_nxt[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = (B == '0) ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_CALC:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
      r_v     <= 1'b0;
    end else if (w_accept) begin
      r_dvd   <= w_a_mag;
      r_div   <= w_b_mag;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
      if (B == '0) begin
        r_q  <= '1;
        r_r  <= A;
        r_dz <= 1'b1;
        r_v  <= 1'b0;
      end
    end else if (r_state == S_CALC) begin
      r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_q  <= w_q_fin;
        r_r  <= w_r_fin;
        r_dz <= 1'b0;
        r_v  <= w_v_fin;
      end
    end
  end

  assign Q  = r_q;
  assign R  = r_r;
  assign DZ = r_dz;
  assign V  = r_v;

endmodule

// File: tb/tb_seq_div_4bits.sv
// tb/tb_seq_div_4bits.sv - self-checking bench for seq_div_4bits with an arithmetic reference model
module tb_seq_div_4bits;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         m_in = 1'b0;
  logic         busy, done, dz, v;
  logic [W-1:0] q, r;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_div_4bits #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
`ifdef DIV_SIGNED_EN
    .M(m_in),
`endif
    .busy(busy), .done(done), .Q(q), .R(r), .DZ(dz), .V(v)
  );

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit m,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic edz, output logic ev);
    int sa, sb, qi, ri;
    if (b == 0) begin
      eq = '1; er = a; edz = 1'b1; ev = 1'b0;
      return;
    end
    edz = 1'b0;
    if (m) begin
      sa = $signed(a);
      sb = $signed(b);
      qi = sa / sb;
      ri = sa % sb;
      ev = (qi > (2 ** (W - 1) - 1));
      eq = qi[W-1:0];
      er = ri[W-1:0];
    end else begin
      eq = a / b;
      er = a % b;
      ev = 1'b0;
    end
  endfunction

  // Pulses start for one cycle, then waits for done; lat counts edges after the accept edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit m,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; m_in = m;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_cycles = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, q, r, dz, v} !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b Q=%h R=%h DZ=%b V=%b expected all 0", busy, done, q, r, dz, v);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_basic();
    int lat, bc;
    run_op(4'd13, 4'd3, 1'b0, lat, bc);
    checks++;
    if (lat !== 4 || bc !== 4) begin
      failures++;
      $display("FAIL div13_3_timing got lat=%0d busy=%0d expected lat=4 busy=4", lat, bc);
    end
    checks++;
    if (q !== 4'd4 || r !== 4'd1 || dz !== 1'b0 || v !== 1'b0) begin
      failures++;
      $display("FAIL div13_3_result got Q=%0d R=%0d DZ=%b V=%b expected Q=4 R=1 DZ=0 V=0", q, r, dz, v);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 4'd4 || r !== 4'd1) begin
      failures++;
      $display("FAIL done_pulse_hold got done=%b busy=%b Q=%0d R=%0d expected done=0 busy=0 Q=4 R=1", done, busy, q, r);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_op(4'd7, 4'd0, 1'b0, lat, bc);
    checks++;
    if (lat !== 0 || bc !== 0) begin
      failures++;
      $display("FAIL div0_timing got lat=%0d busy=%0d expected lat=0 busy=0", lat, bc);
    end
    checks++;
    if (q !== 4'd15 || r !== 4'd7 || dz !== 1'b1 || v !== 1'b0) begin
      failures++;
      $display("FAIL div0_result got Q=%0d R=%0d DZ=%b V=%b expected Q=15 R=7 DZ=1 V=0", q, r, dz, v);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; a_in = 4'd9; b_in = 4'd2; m_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a_in = 4'd15; b_in = 4'd1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || q !== 4'd4 || r !== 4'd1) begin
      failures++;
      $display("FAIL ignore_busy got lat=%0d Q=%0d R=%0d expected lat=4 Q=4 R=1", lat, q, r);
    end
    start = 1'b1; a_in = 4'd15; b_in = 4'd1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL accept_in_done got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || q !== 4'd15 || r !== 4'd0) begin
      failures++;
      $display("FAIL back_to_back got lat=%0d Q=%0d R=%0d expected lat=4 Q=15 R=0", lat, q, r);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    @(negedge clk);
    start = 1'b1; a_in = 4'd14; b_in = 4'd5; m_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, q, r, dz, v} !== '0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b Q=%h R=%h DZ=%b V=%b expected all 0", busy, done, q, r, dz, v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd14, 4'd5, 1'b0, lat, bc);
    checks++;
    if (lat !== 4 || q !== 4'd2 || r !== 4'd4 || dz !== 1'b0) begin
      failures++;
      $display("FAIL after_reset got lat=%0d Q=%0d R=%0d DZ=%b expected lat=4 Q=2 R=4 DZ=0", lat, q, r, dz);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0] ta [3] = '{4'd15, 4'd2, 4'd15};
    logic [W-1:0] tb [3] = '{4'd1, 4'd15, 4'd15};
    logic [W-1:0] tq [3] = '{4'd15, 4'd0, 4'd1};
    logic [W-1:0] tr [3] = '{4'd0, 4'd2, 4'd0};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b0, lat, bc);
      checks++;
      if (lat !== 4 || q !== tq[i] || r !== tr[i] || dz !== 1'b0 || v !== 1'b0) begin
        failures++;
        $display("FAIL corner_%0d_%0d got lat=%0d Q=%0d R=%0d DZ=%b V=%b expected lat=4 Q=%0d R=%0d DZ=0 V=0",
                 ta[i], tb[i], lat, q, r, dz, v, tq[i], tr[i]);
      end
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int lat, bc;
    run_op(4'b1001, 4'd2, 1'b1, lat, bc);
    checks++;
    if (lat !== 4 || q !== 4'b1101 || r !== 4'b1111 || v !== 1'b0) begin
      failures++;
      $display("FAIL signed_m7_2 got lat=%0d Q=%b R=%b V=%b expected lat=4 Q=1101 R=1111 V=0", lat, q, r, v);
    end
    run_op(4'b1000, 4'b1111, 1'b1, lat, bc);
    checks++;
    if (lat !== 4 || q !== 4'b1000 || r !== 4'b0000 || v !== 1'b1) begin
      failures++;
      $display("FAIL signed_ovf got lat=%0d Q=%b R=%b V=%b expected lat=4 Q=1000 R=0000 V=1", lat, q, r, v);
    end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] ra, rb, eq, er;
    logic edz, ev;
    bit   rm;
    int   lat, bc, exp_lat;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 2 ** W - 1));
      rb = W'($urandom_range(0, 2 ** W - 1));
`ifdef DIV_SIGNED_EN
      rm = 1'($urandom_range(0, 1));
`else
      rm = 1'b0;
`endif
      model(ra, rb, rm, eq, er, edz, ev);
      exp_lat = (rb == 0) ? 0 : W;
      run_op(ra, rb, rm, lat, bc);
      checks++;
      if (lat !== exp_lat || q !== eq || r !== er || dz !== edz || v !== ev) begin
        failures++;
        $display("FAIL random_%0d A=%h B=%h M=%b got lat=%0d Q=%h R=%h DZ=%b V=%b expected lat=%0d Q=%h R=%h DZ=%b V=%b",
                 i, ra, rb, rm, lat, q, r, dz, v, exp_lat, eq, er, edz, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_corners();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
